mem_port_arbiter: RTL and testbench

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester. Each requester holds a request until it receives a one-cycle done pulse. The arbiter latches the winning request, drives the memory handshake and bounds every access with a wait-state timeout. It sits between the fetch unit / load-store path and the memory model, and the main controller sees it only through the requester handshakes.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, with a wait-state timeout bounding every memory access.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_err_q, d_err_d;
  logic                busy_q, busy_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_s;
  logic                finish_s;
  logic [DATA_W-1:0]   resp_data_s;
  logic                resp_err_s;

  // Next-state logic: grant in IDLE, wait/timeout in ISSUE, done pulse in RESP
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    wait_cnt_d   = wait_cnt_q;
    if_done_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    if_err_d     = if_err_q;
    d_done_d     = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_err_d      = d_err_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant_s      = d_req && (!if_req || !last_grant_q);
    finish_s     = 1'b0;
    resp_data_s  = '0;
    resp_err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d      = ISSUE;
          mem_req_d    = 1'b1;
          wait_cnt_d   = '0;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          mem_we_d     = grant_s & d_we;
          mem_addr_d   = grant_s ? d_addr : if_addr;
          mem_wdata_d  = grant_s ? d_wdata : '0;
          mem_wstrb_d  = grant_s ? d_wstrb : '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // An ack arriving on the last permitted cycle still completes normally
        if (mem_ack) begin
          finish_s    = 1'b1;
          resp_data_s = mem_we_q ? '0 : mem_rdata;
          resp_err_s  = 1'b0;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          finish_s    = 1'b1;
          resp_data_s = '0;
          resp_err_s  = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      RESP: begin
        state_d    = IDLE;
        if_rdata_d = '0;
        if_err_d   = 1'b0;
        d_rdata_d  = '0;
        d_err_d    = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    if (finish_s) begin
      state_d   = RESP;
      mem_req_d = 1'b0;
      if (owner_q) begin
        d_done_d  = 1'b1;
        d_rdata_d = resp_data_s;
        d_err_d   = resp_err_s;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = resp_data_s;
        if_err_d   = resp_err_s;
      end
    end else begin
      mem_req_d = mem_req_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      wait_cnt_q   <= '0;
      if_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      wait_cnt_q   <= wait_cnt_d;
      if_done_q    <= if_done_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      d_done_q     <= d_done_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts each grant and its response; monitors compare what the DUT presents.
module tb_mem_port_arbiter;
  localparam int TO = 4;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          nreq;
  } mexp_t;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
  } rexp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_done, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy, owner;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  bit mdl_en = 1'b0;
  bit mon_en = 1'b0;
  bit mdl_last = 1'b1;
  int mdl_free = 0;
  mexp_t mem_q[$];
  rexp_t resp_q[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Address bits [4:2] choose the memory latency; 4 and 5 exceed the timeout
  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 5));
    return ($urandom() & 32'hFFFF_FFE0) | (w << 2);
  endfunction

  // Transaction-level reference: round-robin grant and outcome per access
  initial begin : model
    mexp_t m;
    rexp_t r;
    logic [31:0] a;
    int w;
    bit to, pick;
    forever begin
      @(posedge clk);
      if (mdl_en && reset_n && cyc >= mdl_free && (if_req || d_req)) begin
        pick = (if_req && d_req) ? !mdl_last : d_req;
        mdl_last = pick;
        a = pick ? d_addr : if_addr;
        w = int'(a[4:2]);
        to = (w >= TO);
        m.owner = pick;
        m.we    = pick ? d_we : 1'b0;
        m.addr  = a;
        m.wdata = pick ? d_wdata : 32'h0;
        m.wstrb = pick ? d_wstrb : 4'h0;
        m.nreq  = to ? TO : w + 1;
        r.owner = pick;
        r.err   = to;
        r.rdata = (to || m.we) ? 32'h0 : (a ^ KEY);
        r.done_cyc = cyc + m.nreq + 1;
        mem_q.push_back(m);
        resp_q.push_back(r);
        mdl_free = cyc + m.nreq + 2;
      end
    end
  end

  // Memory model: ack after (addr[4:2]+1) request cycles, stray acks while idle
  initial begin : memory
    int cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) cnt++;
      else cnt = 0;
      if (mem_req && cnt == int'(mem_addr[4:2]) + 1) begin
        mem_ack = 1'b1;
        mem_rdata = mem_addr ^ KEY;
      end else begin
        mem_ack = !mem_req && ($urandom_range(0, 1) == 1);
        mem_rdata = $urandom();
      end
    end
  end

  // Memory-side monitor: fields at grant, stability and request length
  initial begin : mem_mon
    mexp_t cur;
    bit have = 1'b0, prev = 1'b0, stable = 1'b1;
    int len = 0;
    forever begin
      @(negedge clk);
      if (mon_en && mem_req && !prev) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected_req", 1'b1, 1'b0);
          have = 1'b0;
        end else begin
          cur = mem_q.pop_front();
          have = 1'b1; len = 0; stable = 1'b1;
          check("mem_fields", {owner, busy, mem_we, mem_addr, mem_wstrb, cur.we ? mem_wdata : 32'h0},
                {cur.owner, 1'b1, cur.we, cur.addr, cur.wstrb, cur.we ? cur.wdata : 32'h0});
        end
      end
      if (mem_req && have) begin
        len++;
        if ({owner, mem_we, mem_addr, mem_wstrb} !== {cur.owner, cur.we, cur.addr, cur.wstrb}
            || (cur.we && mem_wdata !== cur.wdata)) stable = 1'b0;
      end
      if (!mem_req && prev && have) begin
        check("mem_req_len", len, cur.nreq);
        check("mem_fields_stable", stable, 1'b1);
        have = 1'b0;
      end
      prev = mem_req;
    end
  end

  // Requester-side monitor: done pulses against the response scoreboard
  initial begin : done_mon
    rexp_t e;
    bit pif = 1'b0, pd = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (pif || pd)) check("done_single_pulse", {if_done & pif, d_done & pd}, 2'b00);
      if (mon_en && (if_done || d_done)) begin
        if (resp_q.size() == 0) begin
          check("done_unexpected", 1'b1, 1'b0);
        end else begin
          e = resp_q.pop_front();
          check("done_owner", {if_done, d_done}, e.owner ? 2'b01 : 2'b10);
          check("resp_data_err", e.owner ? {d_err, d_rdata} : {if_err, if_rdata}, {e.err, e.rdata});
          check("done_cycle", cyc, e.done_cyc);
        end
      end
      pif = if_done;
      pd = d_done;
    end
  end

  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      repeat (i == 0 ? 0 : $urandom_range(0, 3)) @(negedge clk);
      if_req = 1'b1;
      if_addr = rand_addr();
      forever begin
        @(negedge clk);
        if (if_done) break;
        if (++t > 100) begin check("fetch_done_timeout", 1'b0, 1'b1); break; end
        if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
      end
      if_req = 1'b0;
    end
  endtask

  task automatic run_data(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      repeat (i == 0 ? 0 : $urandom_range(0, 3)) @(negedge clk);
      d_req = 1'b1;
      d_we = 1'($urandom_range(0, 1));
      d_addr = rand_addr();
      d_wdata = $urandom();
      d_wstrb = 4'($urandom_range(1, 15));
      forever begin
        @(negedge clk);
        if (d_done) break;
        if (++t > 100) begin check("data_done_timeout", 1'b0, 1'b1); break; end
        if ($urandom_range(0, 1) == 1) begin
          d_we = ~d_we; d_addr = rand_addr(); d_wdata = $urandom(); d_wstrb = ~d_wstrb;
        end
      end
      d_req = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((mem_q.size() != 0 || resp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, {mem_q.size(), resp_q.size(), 31'h0, busy}, 128'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {if_done, if_rdata, if_err, d_done, d_rdata, d_err, mem_req, mem_we, mem_addr, busy, owner},
          128'h0);
    check("reset_mem_fields", {mem_wdata, mem_wstrb}, 36'h0);

    reset_n = 1'b1;
    mdl_last = 1'b1; mdl_free = 0; mdl_en = 1'b1; mon_en = 1'b1;
    fork
      run_fetch(25);
      run_data(25);
    join
    drain("drain_random");

    // Abandon a timed-out-to-be load by resetting between clock edges
    mdl_en = 1'b0; mon_en = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_001C;
    repeat (3) @(negedge clk);
    check("pre_reset_issue", {mem_req, busy, owner}, 3'b111);
    #2;
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    check("async_reset_drop", {mem_req, busy, owner, if_done, d_done}, 5'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= if_done | d_done;
    end
    check("no_done_after_reset", seen, 1'b0);
    reset_n = 1'b1;
    mdl_last = 1'b1; mdl_free = 0; mdl_en = 1'b1; mon_en = 1'b1;
    run_fetch(4);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
